// File: rtl/wash_sequencer.sv
// Wash program sequencer: loads a packed stage-time word and counts the highest nonzero
// field down on each 1 Hz tick, with a water-fill countdown before every stage.
module wash_sequencer #(
    parameter int WATER_TICKS = 3
) (
    input  logic        cp,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        pause_btn,
    input  logic        abort,
    // "program" is a reserved word in SystemVerilog, so the program word is carried on prog
    input  logic [25:0] prog,
    output logic [25:0] msg,
    output logic [2:0]  waterTime,
    output logic [2:0]  phase,
    output logic        stage_done,
    output logic        finish
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [2:0] WT = 3'(WATER_TICKS);

    // Field 0 is [2:0], field 7 is [25:23]; the highest nonzero index is the active field.
    localparam int FLD_LO [8] = '{0, 3, 6, 10, 13, 16, 19, 23};
    localparam int FLD_W  [8] = '{3, 3, 4, 3, 3, 3, 4, 3};

    state_t      state_reg, state_next;
    state_t      ret_reg, ret_next;
    logic [25:0] msg_reg, msg_next;
    logic [2:0]  water_reg, water_next;
    logic [2:0]  phase_reg, phase_next;
    logic        stage_done_reg, stage_done_next;
    logic        finish_reg, finish_next;

    logic [3:0]  fld [8];
    logic [7:0]  fld_nz;
    logic [25:0] unit [8];
    logic [2:0]  act_idx;
    logic [3:0]  act_val;
    logic [25:0] dec_word;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_fld
            assign fld[gi]    = 4'((msg_reg >> FLD_LO[gi]) & ((26'd1 << FLD_W[gi]) - 26'd1));
            assign fld_nz[gi] = |fld[gi];
            assign unit[gi]   = 26'd1 << FLD_LO[gi];
        end
    endgenerate

    always_comb begin
        act_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (fld_nz[i]) act_idx = 3'(i);
        end
    end

    // The active field is nonzero, so subtracting its unit never borrows out of the field.
    assign act_val  = fld[act_idx];
    assign dec_word = msg_reg - unit[act_idx];

    // State register
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ret_reg        <= S_RUN;
            msg_reg        <= '0;
            water_reg      <= '0;
            phase_reg      <= 3'd1;
            stage_done_reg <= 1'b0;
            finish_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ret_reg        <= ret_next;
            msg_reg        <= msg_next;
            water_reg      <= water_next;
            phase_reg      <= phase_next;
            stage_done_reg <= stage_done_next;
            finish_reg     <= finish_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state_reg;
        ret_next        = ret_reg;
        msg_next        = msg_reg;
        water_next      = water_reg;
        stage_done_next = 1'b0;

        if (abort) begin
            state_next = S_IDLE;
            msg_next   = '0;
            water_next = '0;
        end else if (pause_btn && (state_reg == S_FILL || state_reg == S_RUN)) begin
            ret_next   = state_reg;
            state_next = S_PAUSE;
        end else if (pause_btn && state_reg == S_PAUSE) begin
            state_next = ret_reg;
        end else begin
            case (state_reg)
                S_IDLE, S_FINISH: begin
                    if (start && prog != 26'd0) begin
                        msg_next = prog;
                        if (WT != 3'd0) begin
                            water_next = WT;
                            state_next = S_FILL;
                        end else begin
                            water_next = '0;
                            state_next = S_RUN;
                        end
                    end
                end
                S_FILL: begin
                    if (tick) begin
                        water_next = water_reg - 3'd1;
                        if (water_reg == 3'd1) state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        msg_next = dec_word;
                        if (act_val == 4'd1) begin
                            stage_done_next = 1'b1;
                            if (dec_word == 26'd0) begin
                                water_next = '0;
                                state_next = S_FINISH;
                            end else if (WT != 3'd0) begin
                                water_next = WT;
                                state_next = S_FILL;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic, registered alongside the state
    always_comb begin
        finish_next = (state_next == S_FINISH);
        case (state_next)
            S_IDLE:         phase_next = 3'd1;
            S_FILL, S_RUN:  phase_next = 3'd3;
            S_PAUSE:        phase_next = 3'd5;
            S_FINISH:       phase_next = 3'd6;
            default:        phase_next = 3'd1;
        endcase
    end

    assign msg        = msg_reg;
    assign waterTime  = water_reg;
    assign phase      = phase_reg;
    assign stage_done = stage_done_reg;
    assign finish     = finish_reg;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: one instance with a 3-tick fill phase, one with none.
module tb_wash_sequencer;

    logic        cp = 1'b0;
    logic        rst;
    logic        tick, start, pause_btn, abort;
    logic [25:0] prog;

    logic [25:0] msg3, msg0;
    logic [2:0]  water3, water0, phase3, phase0;
    logic        sd3, sd0, fin3, fin0;

    int nvec  = 0;
    int nfail = 0;

    always #5 cp = ~cp;

    wash_sequencer #(.WATER_TICKS(3)) u_dut (
        .cp(cp), .rst(rst), .tick(tick), .start(start), .pause_btn(pause_btn),
        .abort(abort), .prog(prog), .msg(msg3), .waterTime(water3), .phase(phase3),
        .stage_done(sd3), .finish(fin3)
    );

    wash_sequencer #(.WATER_TICKS(0)) u_dut0 (
        .cp(cp), .rst(rst), .tick(tick), .start(start), .pause_btn(pause_btn),
        .abort(abort), .prog(prog), .msg(msg0), .waterTime(water0), .phase(phase0),
        .stage_done(sd0), .finish(fin0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Holds the inputs across exactly one rising edge; returns on the following falling edge.
    task automatic cyc(input logic t, input logic s, input logic p, input logic a);
        @(negedge cp);
        tick = t; start = s; pause_btn = p; abort = a;
        @(negedge cp);
        tick = 1'b0; start = 1'b0; pause_btn = 1'b0; abort = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; pause_btn = 1'b0; abort = 1'b0; prog = '0;
        repeat (3) @(negedge cp);
        check("reset_msg",   32'(msg3),   32'h0);
        check("reset_water", 32'(water3), 32'h0);
        check("reset_phase", 32'(phase3), 32'h1);
        check("reset_fin",   32'(fin3),   32'h0);
        rst = 1'b0;

        // Idle: zero program is ignored, as are tick and pause
        prog = 26'h0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_phase", 32'(phase3), 32'h1);
        check("t2_msg",   32'(msg3),   32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("t2_idle_tick_phase", 32'(phase3), 32'h1);

        // Two one-tick stages with fill phases in between
        prog = 26'h0000009;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("t1_load_msg",   32'(msg3),   32'h9);
        check("t1_load_water", 32'(water3), 32'h3);
        check("t1_load_phase", 32'(phase3), 32'h3);
        ticks(1);
        check("t1_fill1_water", 32'(water3), 32'h2);
        ticks(2);
        check("t1_fill3_water", 32'(water3), 32'h0);
        check("t1_fill3_msg",   32'(msg3),   32'h9);
        ticks(1);
        check("t1_stage1_msg",  32'(msg3),   32'h1);
        check("t1_stage1_done", 32'(sd3),    32'h1);
        check("t1_stage1_water", 32'(water3), 32'h3);
        ticks(1);
        check("t1_done_pulse_clear", 32'(sd3), 32'h0);
        ticks(2);
        check("t1_fill_end_msg", 32'(msg3), 32'h1);
        ticks(1);
        check("t1_stage2_msg",  32'(msg3),  32'h0);
        check("t1_stage2_done", 32'(sd3),   32'h1);
        check("t1_finish",      32'(fin3),  32'h1);
        check("t1_phase",       32'(phase3), 32'h6);
        ticks(2);
        check("t1_hold_finish", 32'(fin3),  32'h1);
        check("t1_hold_msg",    32'(msg3),  32'h0);
        check("t1_hold_done",   32'(sd3),   32'h0);

        // Start from FINISH reloads; start mid-run is ignored
        prog = 26'h1000000;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("fin_reload_msg",   32'(msg3),   32'h1000000);
        check("fin_reload_fin",   32'(fin3),   32'h0);
        check("fin_reload_water", 32'(water3), 32'h3);
        ticks(3);
        check("t3_run_phase", 32'(phase3), 32'h3);
        prog = 26'h0000005;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("midrun_start_msg", 32'(msg3), 32'h1000000);

        // Pause in RUN discards ticks and resumes where it left off
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_pause_phase", 32'(phase3), 32'h5);
        ticks(5);
        check("t3_paused_msg",   32'(msg3),   32'h1000000);
        check("t3_paused_phase", 32'(phase3), 32'h5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_resume_phase", 32'(phase3), 32'h3);
        ticks(1);
        check("t3_dec_msg",  32'(msg3), 32'h0800000);
        check("t3_dec_done", 32'(sd3),  32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_phase", 32'(phase3), 32'h1);
        check("abort_msg",   32'(msg3),   32'h0);

        // Tick coinciding with pause during FILL is discarded
        prog = 26'h0000009;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check("t4_water_pre", 32'(water3), 32'h2);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("t4_phase", 32'(phase3), 32'h5);
        check("t4_water", 32'(water3), 32'h2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_resume_phase", 32'(phase3), 32'h3);
        ticks(1);
        check("t4_resume_water", 32'(water3), 32'h1);

        // Abort with the final tick suppresses stage_done
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        prog = 26'h0000001;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        check("t5_run_msg", 32'(msg3), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_phase", 32'(phase3), 32'h1);
        check("t5_msg",   32'(msg3),   32'h0);
        check("t5_done",  32'(sd3),    32'h0);
        check("t5_fin",   32'(fin3),   32'h0);

        // Asynchronous reset mid-FILL
        prog = 26'h0000012;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check("t5r_pre_water", 32'(water3), 32'h2);
        @(negedge cp);
        #2 rst = 1'b1;
        #1;
        check("t5r_msg",   32'(msg3),   32'h0);
        check("t5r_water", 32'(water3), 32'h0);
        check("t5r_phase", 32'(phase3), 32'h1);
        check("t5r_done",  32'(sd3),    32'h0);
        check("t5r_fin",   32'(fin3),   32'h0);
        @(negedge cp);
        rst = 1'b0;

        // No fill phase when WATER_TICKS is zero
        prog = 26'h0000002;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_load_msg",   32'(msg0),   32'h2);
        check("t6_load_water", 32'(water0), 32'h0);
        check("t6_load_phase", 32'(phase0), 32'h3);
        ticks(1);
        check("t6_tick1_msg",  32'(msg0), 32'h1);
        check("t6_tick1_done", 32'(sd0),  32'h0);
        ticks(1);
        check("t6_tick2_msg",  32'(msg0),   32'h0);
        check("t6_tick2_done", 32'(sd0),    32'h1);
        check("t6_fin",        32'(fin0),   32'h1);
        check("t6_phase",      32'(phase0), 32'h6);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_abort_phase", 32'(phase0), 32'h1);
        check("t6_abort_fin",   32'(fin0),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
